// File: rtl/wind_pkg.sv
// wind_pkg: shared wind/source encodings and sequencing helpers
package wind_pkg;
   typedef enum logic [1:0] {CALM = 2'b00, R2L = 2'b01, L2R = 2'b10} wind_t;
   typedef enum logic [1:0] {IDLE = 2'b00, MANUAL = 2'b01, AUTO = 2'b10} src_t;
   function automatic wind_t next_seg(input wind_t s);
      return s == CALM ? R2L : s == R2L ? L2R : CALM;
   endfunction
   function automatic wind_t man_code(input logic [1:0] m);
      return m == 2'b11 ? L2R : wind_t'(m);
   endfunction
endpackage

// File: rtl/wind_scheduler_if.sv
// wind_scheduler_if: command inputs and stepped wind outputs of the scheduler
interface wind_scheduler_if;
   import wind_pkg::*;
   logic man_valid;
   logic [1:0] man_w;
   logic auto_en;
   logic pause;
   wind_t w;
   logic step;
   src_t mode;
   wind_t seg;
   modport master(output man_valid, man_w, auto_en, pause, input w, step, mode, seg);
   modport slave(input man_valid, man_w, auto_en, pause, output w, step, mode, seg);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle tick every TICK_DIV cycles, freezable
module tick_prescaler #(
   parameter int TICK_DIV = 25000000,
   parameter int DIV_W = $clog2(TICK_DIV)
) (
   input logic clk,
   input logic reset,
   input logic pause,
   output logic tick
);
   logic [DIV_W-1:0] div_cnt;
   logic wrap;
   assign wrap = div_cnt == DIV_W'(TICK_DIV - 1);
   assign tick = wrap && !pause;
   // free-running divider that holds its count while paused
   always_ff @(posedge clk or negedge reset)
      if (!reset) div_cnt <= '0;
      else if (!pause) div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
endmodule

// File: rtl/wind_scheduler.sv
// wind_scheduler: arbitrates manual/auto wind source and issues stepped wind codes
module wind_scheduler
   import wind_pkg::*;
#(
   parameter int TICK_DIV = 25000000,
   parameter int DWELL = 8,
   parameter int DIV_W = $clog2(TICK_DIV),
   parameter int DWELL_W = $clog2(DWELL) + 1
) (
   input logic clk,
   input logic reset,
   wind_scheduler_if.slave bus
);
   src_t state, nxt;
   wind_t seg_e;
   logic [DWELL_W-1:0] dwell, dwell_e;
   logic tick, restart, last;
   tick_prescaler #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_pre (
      .clk(clk),
      .reset(reset),
      .pause(bus.pause),
      .tick(tick)
   );
   // source arbitration; a fresh entry into AUTO sees the program already restarted
   always_comb begin
      nxt = bus.man_valid ? MANUAL : bus.auto_en ? AUTO : IDLE;
      restart = nxt == AUTO && state != AUTO;
      seg_e = restart ? CALM : bus.seg;
      dwell_e = restart ? '0 : dwell;
      last = dwell_e == DWELL_W'(DWELL - 1);
   end
   // source state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= nxt;
   // step strobe, wind code and auto program, all advancing only on ticks
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         bus.step <= 1'b0;
         bus.w <= CALM;
         bus.seg <= CALM;
         dwell <= '0;
      end else begin
         bus.step <= tick;
         if (tick) bus.w <= nxt == MANUAL ? man_code(bus.man_w) : nxt == AUTO ? seg_e : CALM;
         if (tick && nxt == AUTO) begin
            bus.seg <= last ? next_seg(seg_e) : seg_e;
            dwell <= last ? '0 : dwell_e + DWELL_W'(1);
         end else if (restart) begin
            bus.seg <= CALM;
            dwell <= '0;
         end
      end
   assign bus.mode = state;
endmodule

// File: tb/tb_wind_scheduler.sv
// tb_wind_scheduler: directed stimulus with a step-driven scoreboard of expected wind codes
module tb_wind_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [1:0] exp_q[$];
   wind_scheduler_if bus();
   wind_scheduler #(.TICK_DIV(4), .DWELL(3)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic step_in(input logic [1:0] ew, input int gap);
      int n;
      exp_q.push_back(ew);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.step !== 1'b1 && n < 20);
      chk("step_gap", n, gap);
   endtask
   // monitor: every presented step is compared against the oldest expected code
   always @(negedge clk)
      if (reset && bus.step === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_step actual_w=%0d required=no step", bus.w);
         end else chk("step_w", bus.w, exp_q.pop_front());
      end
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int ns;
      bus.man_valid = 1'b0;
      bus.man_w = 2'b00;
      bus.auto_en = 1'b0;
      bus.pause = 1'b0;
      cyc(3);
      chk("reset_w", bus.w, 0);
      chk("reset_step", bus.step, 0);
      chk("reset_mode", bus.mode, 0);
      chk("reset_seg", bus.seg, 0);
      reset = 1'b1;
      step_in(2'b00, 4);
      step_in(2'b00, 4);
      step_in(2'b00, 4);
      bus.auto_en = 1'b1;
      cyc(1);
      chk("auto_mode", bus.mode, 2);
      step_in(2'b00, 3);
      step_in(2'b00, 4);
      step_in(2'b00, 4);
      step_in(2'b01, 4);
      chk("auto_seg_r2l", bus.seg, 1);
      step_in(2'b01, 4);
      step_in(2'b01, 4);
      step_in(2'b10, 4);
      step_in(2'b10, 4);
      step_in(2'b10, 4);
      step_in(2'b00, 4);
      bus.man_valid = 1'b1;
      bus.man_w = 2'b01;
      cyc(1);
      chk("manual_mode", bus.mode, 1);
      step_in(2'b01, 3);
      bus.man_w = 2'b11;
      step_in(2'b10, 4);
      bus.man_valid = 1'b0;
      bus.man_w = 2'b00;
      step_in(2'b00, 4);
      step_in(2'b00, 4);
      step_in(2'b00, 4);
      step_in(2'b01, 4);
      cyc(1);
      bus.pause = 1'b1;
      ns = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.step === 1'b1) ns++;
      end
      chk("pause_no_step", ns, 0);
      chk("pause_w_hold", bus.w, 1);
      bus.pause = 1'b0;
      step_in(2'b01, 3);
      #2 reset = 1'b0;
      #1;
      chk("async_w", bus.w, 0);
      chk("async_step", bus.step, 0);
      chk("async_mode", bus.mode, 0);
      chk("async_seg", bus.seg, 0);
      @(negedge clk);
      bus.auto_en = 1'b0;
      reset = 1'b1;
      cyc(3);
      bus.man_valid = 1'b1;
      bus.man_w = 2'b10;
      step_in(2'b10, 1);
      chk("coincident_mode", bus.mode, 1);
      cyc(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wind_scheduler.md
Name: wind_scheduler

Overview:
- Controller that sequences the wind-direction lane-light FSM.
- Divides the fast system clock into a slow step strobe.
- Arbitrates the wind-direction command between manual switches and a built-in auto program.
- Presents a glitch-free 2-bit wind code, qualified by the step strobe, to the downstream light pattern FSM.

Parameters:
TICK_DIV, 25000000, clk cycles per step (>=2).
DWELL, 8, steps each auto segment is held (>=1).
DIV_W, $clog2(TICK_DIV), prescaler counter width.
DWELL_W, $clog2(DWELL)+1, dwell counter width.

Ports:
clk  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-low (asserted at 0): clears all state immediately, no clock edge needed.
man_valid  input  1  manual override request (highest priority).
man_w  input  2  manual wind code: 00 calm, 01 right-to-left, 10 left-to-right, 11 treated as 10.
auto_en  input  1  enable auto program when no manual request.
pause  input  1  freeze prescaler; no steps issued.
w  output  2  wind code to light FSM; never 11.
step  output  1  one-cycle strobe; light FSM advances when step=1, sampling w.
mode  output  2  source state: 00 IDLE, 01 MANUAL, 10 AUTO.
seg  output  2  current auto segment code (CALM/R2L/L2R).

Behaviour:
- Reset values: w=00, step=0, mode=00, seg=00; prescaler=0, dwell=0, state IDLE.
- Reset asserted mid-operation clears everything asynchronously. First step after release comes on the TICK_DIV-th rising edge.
- Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (div_cnt==TICK_DIV-1) && !pause.
  - pause=1 holds div_cnt; it resumes from the held value.
- step is registered: high for exactly the one cycle after the tick edge. Period is TICK_DIV cycles when not paused.
- w is loaded only on the tick edge, so w and step change together. w is stable between steps.
- Source FSM (IDLE, MANUAL, AUTO) is evaluated every cycle, independent of tick:
  - Any state -> MANUAL when man_valid=1.
  - Otherwise -> AUTO when auto_en=1.
  - Otherwise -> IDLE.
- Entering AUTO from IDLE or MANUAL restarts the program: seg=CALM, dwell=0.
- The value loaded into w at a tick uses the next-state source, so a source change in the tick cycle takes effect on that step.
  - IDLE: w <= 00.
  - MANUAL: w <= (man_w==11 ? 10 : man_w).
  - AUTO: w <= seg. Then if dwell==DWELL-1: dwell<=0 and seg advances CALM->R2L->L2R->CALM. Else dwell increments.
- dwell and seg change only on ticks in AUTO, or on restart.
- mode reflects the registered state, updated one cycle after the input change.

Decomposition:
- Package wind_pkg:
  - wind_t enum: CALM=2'b00, R2L=2'b01, L2R=2'b10.
  - src_t enum: IDLE=2'b00, MANUAL=2'b01, AUTO=2'b10.
  - Function next_seg(wind_t).
- Sub-module tick_prescaler (params TICK_DIV, DIV_W; ports clk, reset, pause, tick): holds div_cnt and its wrap.
- wind_scheduler holds the source FSM, auto program, w/step registers.

Test Plan:
All tests use TICK_DIV=4, DWELL=3.

1. Reset and idle: reset=0 for 3 cycles -> w=00, step=0, mode=00. Release with inputs 0 -> step pulses every 4 cycles, first on the 4th edge; w stays 00.
2. Auto program: auto_en=1 -> mode=10 one cycle later. w on successive steps is 00,00,00,01,01,01,10,10,10,00.
3. Manual override: mid-auto, set man_valid=1, man_w=01 -> mode=01; next step w=01.
   - man_w=11 -> next step w=10.
   - Drop man_valid with auto_en=1 -> three steps of w=00, then 01.
4. Pause: pause=1 when div_cnt=1, held 10 cycles -> no step, w unchanged. Release -> next step after exactly 3 more cycles.
5. Async reset mid-AUTO (seg=R2L): drop reset between edges -> w=00, step=0, mode=00 immediately, without a clock edge.
6. Coincident events: man_valid rises with man_w=10 in the same cycle div_cnt=3 -> that step shows w=10, and mode=01 the same cycle.
